// File: rtl/seg7_scan_driver.sv
// Multiplexed multi-digit 7-segment driver: prescaled digit scan, anti-ghost guard,
// leading-zero blanking, dash for non-BCD codes, and frame-synchronous display updates.
module seg7_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned GUARD       = 2,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(DIGITS);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] display, pending;
  logic [DIGITS-1:0]   disp_dp, pend_dp;
  logic                pend_flag;

  logic                slot_end, wrap, on, blank;
  logic [3:0]          nib;
  logic [6:0]          dec, seg_l;
  logic                dp_l;
  logic [DIGITS-1:0]   an_l;

  assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx == IW'(DIGITS - 1));
  assign on       = (cnt >= CW'(GUARD));
  assign nib      = display[4*idx +: 4];

  always_comb begin
    unique case (nib)
      4'd0:    dec = 7'h7E;
      4'd1:    dec = 7'h30;
      4'd2:    dec = 7'h6D;
      4'd3:    dec = 7'h79;
      4'd4:    dec = 7'h33;
      4'd5:    dec = 7'h5B;
      4'd6:    dec = 7'h5F;
      4'd7:    dec = 7'h70;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h7B;
      default: dec = 7'h01;
    endcase
  end

  // Digit i is blanked when it and every more-significant nibble are zero; digit 0 never is.
  always_comb begin
    logic all_zero;
    blank    = 1'b0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (display[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) blank = all_zero;
    end
  end

  always_comb begin
    seg_l = (on && !(blank_lz && blank)) ? dec : 7'h00;
    dp_l  = on && disp_dp[idx];
    an_l  = on ? (DIGITS'(1) << idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      display    <= '0;
      disp_dp    <= '0;
      pending    <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      seg        <= {7{ACTIVE_LOW}};
      dp         <= ACTIVE_LOW;
      an         <= {DIGITS{ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      // Transfer uses the pending value from before this edge, so a coinciding load waits a frame.
      if (wrap && pend_flag) begin
        display <= pending;
        disp_dp <= pend_dp;
      end
      if (load) begin
        pending   <= bcd_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (wrap) begin
        pend_flag <= 1'b0;
      end
      seg        <= seg_l ^ {7{ACTIVE_LOW}};
      dp         <= dp_l ^ ACTIVE_LOW;
      an         <= an_l ^ {DIGITS{ACTIVE_LOW}};
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver, checked against a frame-level
// arithmetic model of scan position, pending/display hand-off and decode.
module tb_seg7_scan_driver;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam logic [6:0] DEC [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};

  logic          clk = 1'b0;
  logic          rst, load, blank_lz;
  logic [15:0]   bcd_in;
  logic [3:0]    dp_in;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  seg7_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(RD), .GUARD(G), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: k = cycles elapsed since reset release.
  int          k;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpd, m_dpp;
  bit          m_pf;
  int          first_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; m_disp = '0; m_pend = '0; m_dpd = '0; m_dpp = '0; m_pf = 0;
  endtask

  // One clock: expected outputs come from model state before the edge, then model advances.
  task automatic step();
    int          ph, sl;
    bit          on, blk, wr;
    logic [3:0]  nib;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    @(posedge clk);
    ph  = k % RD;
    sl  = (k / RD) % D;
    on  = ph >= G;
    nib = 4'((m_disp >> (4 * sl)) & 16'hF);
    blk = blank_lz && sl > 0 && ((m_disp >> (4 * sl)) == 16'h0);
    e_seg = ~((on && !blk) ? DEC[nib] : 7'h00);
    e_dp  = ~(on && m_dpd[sl]);
    e_an  = ~(on ? 4'(1 << sl) : 4'h0);
    wr    = (k % (D * RD)) == D * RD - 1;
    if (wr && m_pf) begin
      m_disp = m_pend; m_dpd = m_dpp; m_pf = 0;
    end
    if (load) begin
      m_pend = bcd_in; m_dpp = dp_in; m_pf = 1;
    end
    k++;
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("frame_done", 32'(frame_done), 32'(wr));
    check("an_no_overlap", 32'($countones(~an) <= 1), 32'd1);
    if (frame_done && first_fd < 0) first_fd = k;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; bcd_in = v; dp_in = d;
    step();
    load = 1'b0;
  endtask

  task automatic run_to_wrap_cycle();
    for (int i = 0; i < D * RD && (k % (D * RD)) != D * RD - 1; i++) step();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; bcd_in = '0; dp_in = '0;
    first_fd = -1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    rst = 1'b0;
    model_reset();
    run(40);
    check("first_frame_done", 32'(first_fd), 32'd32);

    do_load(16'h1234, 4'b0000);
    run(64);

    blank_lz = 1'b1;
    do_load(16'h0050, 4'b1000);
    run(40);
    blank_lz = 1'b0;
    run(32);

    do_load(16'hA009, 4'b0101);
    run(64);
    blank_lz = 1'b1;
    run(32);
    blank_lz = 1'b0;

    do_load(16'h1111, 4'b0000);
    run(40);
    run(12);
    do_load(16'h2222, 4'b0000);
    run(48);

    run_to_wrap_cycle();
    do_load(16'h5678, 4'b0010);
    run(80);

    run(10);
    do_load(16'h0001, 4'b0000);
    do_load(16'h0002, 4'b0000);
    do_load(16'h0003, 4'b0000);
    run(64);

    // Asynchronous reset mid-slot with a load still pending.
    do_load(16'h9999, 4'b1111);
    for (int i = 0; i < RD && (k % RD) != 4; i++) step();
    #2 rst = 1'b1;
    #1;
    check("amid_seg", 32'(seg), 32'h7F);
    check("amid_dp", 32'(dp), 32'h1);
    check("amid_an", 32'(an), 32'hF);
    check("amid_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    first_fd = -1;
    run(70);
    check("first_frame_done_2", 32'(first_fd), 32'd32);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 9) == 0) begin
        do_load(16'($urandom), 4'($urandom));
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
